// File: rtl/mips_pkg.sv
// Shared writeback types and register-file constants for the write-port arbiter, writeback and hazard logic.
// Pure declarations: no latency, no flow control.
package mips_pkg;
  localparam int         NUM_GPR  = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // rd stands in for the register field, since "reg" is a reserved word.
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  function automatic logic [NUM_GPR-1:0] reg_onehot(input logic [4:0] r);
    reg_onehot = '0;
    if (r != REG_ZERO) reg_onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer of deferred GPR writes with per-entry valid, kill-by-register and a pending-register mask.
// Push/pop take effect at the clock edge; the caller must not push when full or pop when empty.
module wb_pend_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [4:0]         push_rd_i,
  input  logic [31:0]        push_data_i,
  input  logic               pop_i,
  input  logic               kill_i,
  input  logic [4:0]         kill_rd_i,
  output wb_req_t            head_o,
  output logic [CW-1:0]      count_o,
  output logic [NUM_GPR-1:0] pend_mask_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  // Push is applied after kill, so a same-cycle offer to the killed register survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && rd_q[i] == kill_rd_i) valid_q[i] <= 1'b0;
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push_i) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pend_mask_o = pend_mask_o | reg_onehot(rd_q[i]);
    end
  end

  assign head_o  = '{we: valid_q[rd_ptr_q] && (count_q != '0), rd: rd_q[rd_ptr_q], data: data_q[rd_ptr_q]};
  assign count_o = count_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline W stage first, then buffered mul/div results, then a 0-cycle bypass.
// md_ready drops only when the buffer is full; BubbleReq asks for a free slot when the head has waited too long.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RegWriteW,
  input  logic [4:0]         WriteRegW,
  input  logic [31:0]        ResultW,
  input  logic               md_valid,
  input  logic [4:0]         md_reg,
  input  logic [31:0]        md_data,
  output logic               md_ready,
  output logic               RegWriteRF,
  output logic [4:0]         WriteRegRF,
  output logic [31:0]        ResultRF,
  output logic [NUM_GPR-1:0] PendingMask,
  output logic               BubbleReq
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  wb_req_t            head;
  logic [CW-1:0]      count;
  logic [NUM_GPR-1:0] pend_mask;
  logic               pipe_real, offer_real, fifo_empty, head_dead;
  logic               pop, push, bypass;
  logic [WW-1:0]      wait_q, wait_d;
  logic               bubble_q, bubble_d;

  assign pipe_real  = RegWriteW && (WriteRegW != REG_ZERO);
  assign offer_real = md_valid && (md_reg != REG_ZERO);
  assign fifo_empty = (count == '0);
  assign head_dead  = !fifo_empty && !head.we;
  assign md_ready   = !reset && (count < CW'(DEPTH));
  assign push       = offer_real && md_ready && !bypass;

  always_comb begin
    RegWriteRF = 1'b0;
    WriteRegRF = '0;
    ResultRF   = '0;
    pop        = 1'b0;
    bypass     = 1'b0;
    if (!reset) begin
      if (pipe_real) begin
        RegWriteRF = 1'b1;
        WriteRegRF = WriteRegW;
        ResultRF   = ResultW;
      end else if (head.we) begin
        RegWriteRF = 1'b1;
        WriteRegRF = head.rd;
        ResultRF   = head.data;
        pop        = 1'b1;
      end else if (fifo_empty && offer_real) begin
        RegWriteRF = 1'b1;
        WriteRegRF = md_reg;
        ResultRF   = md_data;
        bypass     = 1'b1;
      end
      // A killed head needs no port slot, so it drains even under pipeline writes.
      if (head_dead) pop = 1'b1;
    end
  end

  wb_pend_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_rd_i   (md_reg),
    .push_data_i (md_data),
    .pop_i       (pop),
    .kill_i      (pipe_real),
    .kill_rd_i   (WriteRegW),
    .head_o      (head),
    .count_o     (count),
    .pend_mask_o (pend_mask)
  );

  always_comb begin
    wait_d = wait_q;
    if (pop || fifo_empty)                     wait_d = '0;
    else if (head.we && wait_q < WW'(MAX_WAIT)) wait_d = wait_q + WW'(1);
  end

  // Gating with !pop makes the request drop the cycle after the head leaves.
  assign bubble_d = head.we && !pop && ((wait_q >= WW'(MAX_WAIT)) || (count == CW'(DEPTH)));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q   <= '0;
      bubble_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      bubble_q <= bubble_d;
    end
  end

  assign BubbleReq   = bubble_q && !reset;
  assign PendingMask = reset ? '0 : pend_mask;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: a monitor scoreboards every port write, and per-feature tasks check handshake, mask and bubble timing.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWriteW = 1'b0;
  logic [4:0]  WriteRegW = '0;
  logic [31:0] ResultW = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_reg = '0;
  logic [31:0] md_data = '0;
  logic        md_ready, RegWriteRF, BubbleReq;
  logic [4:0]  WriteRegRF;
  logic [31:0] ResultRF, PendingMask;

  typedef struct {logic [4:0] rd; logic [31:0] data;} exp_t;
  exp_t        sb[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .RegWriteRF(RegWriteRF), .WriteRegRF(WriteRegRF), .ResultRF(ResultRF),
    .PendingMask(PendingMask), .BubbleReq(BubbleReq)
  );

  always #5 clk = ~clk;

  // Scoreboard: accepted real offers are queued, pipeline writes kill older queued results to the same register.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (RegWriteW && WriteRegW != 5'd0) begin
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].rd == WriteRegW) sb.delete(i);
      end
      if (md_valid && md_ready && md_reg != 5'd0) sb.push_back('{md_reg, md_data});
      if (RegWriteRF) begin
        checks++;
        if (RegWriteW && WriteRegW != 5'd0) begin
          if (WriteRegRF !== WriteRegW || ResultRF !== ResultW) begin
            errors++; $display("FAIL pipe_write got r%0d=%h exp r%0d=%h", WriteRegRF, ResultRF, WriteRegW, ResultW);
          end
        end else if (sb.size() == 0) begin
          errors++; $display("FAIL spurious_write got r%0d=%h exp no write", WriteRegRF, ResultRF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (WriteRegRF !== e.rd || ResultRF !== e.data) begin
            errors++; $display("FAIL md_write got r%0d=%h exp r%0d=%h", WriteRegRF, ResultRF, e.rd, e.data);
          end
        end
        rf[WriteRegRF] = ResultRF;
      end else if (RegWriteW && WriteRegW != 5'd0) begin
        checks++; errors++; $display("FAIL pipe_dropped got no write exp r%0d", WriteRegW);
      end
    end
  end

  task automatic drive(input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdat);
    RegWriteW = pw; WriteRegW = pr; ResultW = pd;
    md_valid = mv; md_reg = mr; md_data = mdat;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (RegWriteRF !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", RegWriteRF); end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b exp 0", md_ready); end
      checks++; if (PendingMask !== 32'h0 || BubbleReq !== 1'b0) begin
        errors++; $display("FAIL rst_state got mask=%h bub=%b exp 0/0", PendingMask, BubbleReq); end
      next();
    end
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next();
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL byp_rdy got %b exp 1", md_ready); end
    checks++; if (RegWriteRF !== 1'b1 || WriteRegRF !== 5'd5 || ResultRF !== 32'hDEADBEEF) begin
      errors++; $display("FAIL byp_write got %b r%0d=%h exp 1 r5=deadbeef", RegWriteRF, WriteRegRF, ResultRF); end
    checks++; if (PendingMask !== 32'h0) begin errors++; $display("FAIL byp_mask got %h exp 0", PendingMask); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (PendingMask !== 32'h0 || RegWriteRF !== 1'b0) begin
      errors++; $display("FAIL byp_after got mask=%h we=%b exp 0/0", PendingMask, RegWriteRF); end
    next();
  endtask

  task automatic test_buffered();
    drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h11);
    @(negedge clk);
    checks++; if (PendingMask !== 32'h0) begin errors++; $display("FAIL buf_mask0 got %h exp 0", PendingMask); end
    next();
    for (int c = 1; c < 3; c++) begin
      drive(1'b1, 5'd8, 32'h80 + c, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++; if (PendingMask !== 32'h200) begin errors++; $display("FAIL buf_mask got %h exp 200", PendingMask); end
      next();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b1 || WriteRegRF !== 5'd9 || PendingMask !== 32'h200) begin
      errors++; $display("FAIL buf_drain got %b r%0d mask=%h exp 1 r9 200", RegWriteRF, WriteRegRF, PendingMask); end
    next();
    @(negedge clk);
    checks++; if (PendingMask !== 32'h0 || RegWriteRF !== 1'b0) begin
      errors++; $display("FAIL buf_clear got mask=%h we=%b exp 0/0", PendingMask, RegWriteRF); end
    next();
  endtask

  task automatic test_back_to_back_full();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'd10, 32'h1000 + c, 1'b1, 5'd11 + 5'(c), 32'h2000 + c);
      @(negedge clk);
      checks++; if (md_ready !== 1'b1 || BubbleReq !== 1'b0) begin
        errors++; $display("FAIL full_fill%0d got rdy=%b bub=%b exp 1/0", c, md_ready, BubbleReq); end
      next();
    end
    drive(1'b1, 5'd10, 32'h1004, 1'b1, 5'd15, 32'h2004);
    @(negedge clk);
    checks++; if (md_ready !== 1'b0 || BubbleReq !== 1'b0) begin
      errors++; $display("FAIL full_5th got rdy=%b bub=%b exp 0/0", md_ready, BubbleReq); end
    next();
    @(negedge clk);
    checks++; if (md_ready !== 1'b0 || BubbleReq !== 1'b1) begin
      errors++; $display("FAIL full_bub got rdy=%b bub=%b exp 0/1", md_ready, BubbleReq); end
    next();
    RegWriteW = 1'b0;
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b1 || WriteRegRF !== 5'd11 || md_ready !== 1'b0) begin
      errors++; $display("FAIL full_slot got %b r%0d rdy=%b exp 1 r11 0", RegWriteRF, WriteRegRF, md_ready); end
    next();
    @(negedge clk);
    checks++; if (BubbleReq !== 1'b0 || md_ready !== 1'b1 || WriteRegRF !== 5'd12) begin
      errors++; $display("FAIL full_after got bub=%b rdy=%b r%0d exp 0 1 r12", BubbleReq, md_ready, WriteRegRF); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (4) next();
    @(negedge clk);
    checks++; if (PendingMask !== 32'h0) begin errors++; $display("FAIL full_drained got %h exp 0", PendingMask); end
    next();
  endtask

  task automatic test_waw_kill();
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 32'hAA);
    next();
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (PendingMask !== 32'h80) begin errors++; $display("FAIL kill_mask got %h exp 80", PendingMask); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (PendingMask !== 32'h0 || RegWriteRF !== 1'b0) begin
      errors++; $display("FAIL kill_pop got mask=%h we=%b exp 0/0", PendingMask, RegWriteRF); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b1 || WriteRegRF !== 5'd6) begin
      errors++; $display("FAIL kill_empty got %b r%0d exp 1 r6", RegWriteRF, WriteRegRF); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (rf[7] !== 32'hBB) begin errors++; $display("FAIL kill_rf got %h exp bb", rf[7]); end
    next();
  endtask

  task automatic test_max_wait();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'h55);
    next();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 5'd2, 32'h22 + k, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++; if (BubbleReq !== (k == 10)) begin
        errors++; $display("FAIL wait_bub%0d got %b exp %b", k, BubbleReq, (k == 10)); end
      next();
    end
    RegWriteW = 1'b0;
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b1 || WriteRegRF !== 5'd20 || BubbleReq !== 1'b1) begin
      errors++; $display("FAIL wait_pop got %b r%0d bub=%b exp 1 r20 1", RegWriteRF, WriteRegRF, BubbleReq); end
    next();
    @(negedge clk);
    checks++; if (BubbleReq !== 1'b0 || PendingMask !== 32'h0) begin
      errors++; $display("FAIL wait_done got bub=%b mask=%h exp 0/0", BubbleReq, PendingMask); end
    next();
  endtask

  task automatic test_reg0_and_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
    @(negedge clk);
    checks++; if (md_ready !== 1'b1 || RegWriteRF !== 1'b0 || PendingMask !== 32'h0) begin
      errors++; $display("FAIL r0_offer got rdy=%b we=%b mask=%h exp 1 0 0", md_ready, RegWriteRF, PendingMask); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b0) begin errors++; $display("FAIL r0_nopush got %b exp 0", RegWriteRF); end
    next();
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd21, 32'h21);
    next();
    drive(1'b1, 5'd3, 32'h4, 1'b1, 5'd22, 32'h22);
    next();
    drive(1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (PendingMask !== 32'h0060_0000) begin errors++; $display("FAIL pre_rst_mask got %h exp 00600000", PendingMask); end
    next();
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h6, 1'b1, 5'd23, 32'h77);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (RegWriteRF !== 1'b0 || md_ready !== 1'b0 || PendingMask !== 32'h0 || BubbleReq !== 1'b0) begin
        errors++; $display("FAIL mid_rst got we=%b rdy=%b mask=%h bub=%b exp 0 0 0 0", RegWriteRF, md_ready, PendingMask, BubbleReq); end
      next();
    end
    reset = 1'b0;
    RegWriteW = 1'b0;
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b1 || WriteRegRF !== 5'd23 || ResultRF !== 32'h77 || PendingMask !== 32'h0) begin
      errors++; $display("FAIL post_rst_byp got %b r%0d=%h mask=%h exp 1 r23=77 0", RegWriteRF, WriteRegRF, ResultRF, PendingMask); end
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (RegWriteRF !== 1'b0 || PendingMask !== 32'h0) begin
      errors++; $display("FAIL post_rst_empty got we=%b mask=%h exp 0/0", RegWriteRF, PendingMask); end
    next();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_buffered();
    test_back_to_back_full();
    test_waw_kill();
    test_max_wait();
    test_reg0_and_reset();
    repeat (2) next();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline's writeback stage and the multi-cycle multiply/divide unit, which returns GPR results out of band.
- The pipeline always has priority, because the W stage cannot stall.
- Multiply/divide results wait in a small buffer until a free write slot appears.
- Provides a pending-register mask for the hazard unit, and a bubble request that forces a free slot when a buffered result has waited too long.

Parameters:
- DEPTH, 4: number of buffered multiply/divide results; power of two, minimum 2.
- MAX_WAIT, 8: cycles the buffer head may wait before a bubble is requested; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- RegWriteW  in  1  pipeline W-stage write enable.
- WriteRegW  in  5  pipeline W-stage destination register.
- ResultW  in  32  pipeline W-stage result.
- md_valid  in  1  multiply/divide unit offers a result.
- md_reg  in  5  destination of the offered result.
- md_data  in  32  data of the offered result.
- md_ready  out  1  arbiter accepts the offer this cycle.
- RegWriteRF  out  1  register-file write enable.
- WriteRegRF  out  5  register-file write address.
- ResultRF  out  32  register-file write data.
- PendingMask  out  32  one-hot OR of destinations held in the buffer; bit 0 is always 0.
- BubbleReq  out  1  asks the hazard unit to insert a non-writing bubble.

Behaviour:
- A write is "real" only when its destination is not register 0.
  - Pipeline write real: RegWriteW=1 and WriteRegW!=0.
  - Offer real: md_reg!=0.
- Per-cycle port grant is combinational, evaluated in this priority order:
  1. Pipeline write is real: drive the port with RegWriteW, WriteRegW, ResultW.
  2. Else, buffer head is valid: drive the port with the head, then pop it.
  3. Else, buffer is empty and md_valid with a real offer: bypass; drive the port with md_reg/md_data. Nothing is pushed.
  4. Else: RegWriteRF=0. WriteRegRF and ResultRF are don't-care; drive 0.
- md_ready = (count < DEPTH).
  - This is independent of a same-cycle pop; no pop-to-push forwarding.
- Push: occurs when md_valid && md_ready, the offer is real, and the offer was not bypassed.
  - An offer to register 0 is handshaken and discarded.
- Simultaneous pop and push: count is unchanged; the pushed entry goes behind the remaining entries.
- Buffer entry format: {valid, reg[4:0], data[31:0]}; FIFO order, wrapping pointers.
- WAW kill: a real pipeline write to register R clears valid on every buffered entry whose reg == R, at the clock edge.
  - The pipeline instruction is younger, so its value wins.
  - An offer arriving in the same cycle to the same R is still pushed; the offer is the newest value.
- Killed head (valid=0, count>0): popped without using the port, in any cycle, including cycles in which the pipeline writes.
- PendingMask: combinational OR over valid entries of (1<<reg).
  - A bypassed offer never appears in it.
  - A popped entry clears from it in the following cycle.
- Wait counter wait_cnt, width clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, while the head is valid and not popped.
  - Clears to 0 on any pop or when the buffer is empty.
- BubbleReq = head valid && (wait_cnt >= MAX_WAIT || count == DEPTH), registered.
  - It deasserts the cycle after the head pops.
  - The hazard unit guarantees a W-stage bubble within 4 cycles of assertion.
- Reset, synchronous, held for 1 or more cycles:
  - count=0, pointers=0, all valid bits=0, wait_cnt=0, BubbleReq=0.
  - While reset=1: RegWriteRF=0, md_ready=0, PendingMask=0.
  - Reset during a pending offer drops the offer; md_valid may remain high afterwards and is accepted once reset deasserts.
- Latency:
  - Bypass: 0 cycles from offer to write.
  - Buffered: 1 or more cycles.
  - Port write itself: same cycle as the grant; the register file captures at its write edge.

Decomposition:
- Shared package (mips_pkg):
  - NUM_GPR=32.
  - REG_ZERO=5'd0.
  - Typedef wb_req_t {logic we; logic [4:0] reg; logic [31:0] data}, also used by writeback and hazard.
- One natural sub-module: wb_pend_fifo.
  - DEPTH-entry circular buffer with per-entry valid, a kill-by-register input, head/count outputs and a pending mask.
- The arbiter top holds only the grant mux, handshake, wait counter and bubble logic.

Test Plan:
- Idle pipeline, empty buffer; md_valid with md_reg=5, md_data=0xDEADBEEF.
  -> Same cycle: md_ready=1, RegWriteRF=1, WriteRegRF=5, ResultRF=0xDEADBEEF; PendingMask stays 0.
- Pipeline writes reg 8 for 3 cycles while md offers reg 9 with value 0x11.
  -> Pushed; PendingMask=0x200 for 3 cycles; written in the first free cycle; mask then clears.
- Pipeline writes continuously; 5 offers with DEPTH=4.
  -> md_ready=0 on the 5th offer; BubbleReq=1 the cycle after count reaches 4.
  -> The head writes in the first bubble cycle.
- Buffer holds reg 7 with value 0xAA; pipeline writes reg 7 with value 0xBB.
  -> Entry killed; PendingMask bit 7 clears; the head pops next cycle with no write to the port; the register file holds 0xBB.
- Head waits MAX_WAIT=8 cycles under continuous pipeline writes.
  -> BubbleReq asserts after cycle 8; deasserts one cycle after the head pops.
- Offer to reg 0; then reset asserted with 2 entries buffered.
  -> Reg-0 offer is handshaken with no write and no push.
  -> During reset: RegWriteRF=0, md_ready=0, PendingMask=0, BubbleReq=0; the buffer is empty after reset.
